// File: rtl/dmem_port_arbiter.sv
// Arbitrates the single-port data memory between the CPU memory stage and a DMA/loader port; CPU access 0 wait, DMA read data 1 cycle after dma_gnt.
// Backpressure: a losing CPU sees cpu_stall and holds its inputs; a losing DMA sees dma_gnt=0 and holds its request.
module dmem_port_arbiter #(
   parameter int AW         = 32,
   parameter int DW         = 32,
   parameter int STARVE_MAX = 4,
   parameter int BURST_MAX  = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          cpu_req,
   input  logic          cpu_we,
   input  logic [AW-1:0] cpu_addr,
   input  logic [DW-1:0] cpu_wdata,
   output logic [DW-1:0] cpu_rdata,
   output logic          cpu_stall,
   input  logic          dma_req,
   input  logic          dma_we,
   input  logic [AW-1:0] dma_addr,
   input  logic [DW-1:0] dma_wdata,
   output logic          dma_gnt,
   output logic          dma_rvalid,
   output logic [DW-1:0] dma_rdata,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wd,
   input  logic [DW-1:0] mem_rd,
   output logic [15:0]   stall_cnt
);

   localparam int SW = $clog2(STARVE_MAX + 1);
   localparam int BW = $clog2(BURST_MAX + 1);
   localparam logic [SW-1:0] STARVE_TOP = SW'(STARVE_MAX);
   localparam logic [BW-1:0] BURST_TOP  = BW'(BURST_MAX);

   typedef enum logic {S_CPU, S_DMA} state_t;

   state_t        state, state_nxt;
   logic [SW-1:0] starve_cnt, starve_nxt;
   logic [BW-1:0] beat_cnt, beat_nxt;
   logic          dma_sel;

   always_comb begin
      dma_sel    = 1'b0;
      state_nxt  = state;
      beat_nxt   = beat_cnt;
      starve_nxt = starve_cnt;

      if (state == S_CPU) begin
         dma_sel = dma_req & (~cpu_req | (starve_cnt == STARVE_TOP));
      end else begin
         dma_sel = dma_req & ~(cpu_req & (beat_cnt == BURST_TOP));
      end
      // Holding reset low must block any memory write even with live requests.
      dma_sel = dma_sel & rst;

      if (dma_sel) begin
         state_nxt  = S_DMA;
         starve_nxt = '0;
         if (state == S_CPU) begin
            beat_nxt = BW'(1);
         end else if (beat_cnt != BURST_TOP) begin
            beat_nxt = beat_cnt + BW'(1);
         end
      end else begin
         state_nxt = S_CPU;
         beat_nxt  = '0;
         if (!dma_req) begin
            starve_nxt = '0;
         end else if (starve_cnt != STARVE_TOP) begin
            starve_nxt = starve_cnt + SW'(1);
         end
      end
   end

   assign dma_gnt   = dma_sel;
   assign cpu_stall = cpu_req & dma_sel;
   assign cpu_rdata = mem_rd;
   assign mem_addr  = dma_sel ? dma_addr : cpu_addr;
   assign mem_wd    = dma_sel ? dma_wdata : cpu_wdata;
   assign mem_we    = dma_sel ? dma_we : (rst & cpu_req & cpu_we);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= S_CPU;
         starve_cnt <= '0;
         beat_cnt   <= '0;
         dma_rvalid <= 1'b0;
         dma_rdata  <= '0;
         stall_cnt  <= '0;
      end else begin
         state      <= state_nxt;
         starve_cnt <= starve_nxt;
         beat_cnt   <= beat_nxt;
         dma_rvalid <= dma_sel & ~dma_we;
         if (dma_sel & ~dma_we) begin
            dma_rdata <= mem_rd;
         end
         if (cpu_stall && (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 16'd1;
         end
      end
   end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Randomized and directed checks of dmem_port_arbiter against a run-length based reference model.
module tb_dmem_port_arbiter;

   localparam int STARVE = 4;
   localparam int BURST  = 4;
   localparam int SAT_B  = 1000;

   logic        clk = 1'b0;
   logic        rst;
   logic        cpu_req, cpu_we, dma_req, dma_we;
   logic [31:0] cpu_addr, cpu_wdata, dma_addr, dma_wdata;
   logic [31:0] cpu_rdata, dma_rdata, mem_addr, mem_wd, mem_rd;
   logic        cpu_stall, dma_gnt, dma_rvalid, mem_we;
   logic [15:0] stall_cnt;

   logic        s_req;
   logic [31:0] s_cpu_rdata, s_dma_rdata, s_mem_addr, s_mem_wd;
   logic        s_cpu_stall, s_dma_gnt, s_dma_rvalid, s_mem_we;
   logic [15:0] s_stall_cnt;

   logic [31:0] ram [256];
   logic [31:0] ref_mem [256];

   int vectors = 0;
   int miscompares = 0;

   // Model: lengths of the current DMA run and of the current DMA wait.
   int          m_run, m_wait, m_stall;
   bit          m_rvalid, m_last_gnt, m_last_stall;
   logic [31:0] m_rdata;

   always #5 clk = ~clk;

   dmem_port_arbiter #(.AW(32), .DW(32), .STARVE_MAX(STARVE), .BURST_MAX(BURST)) dut (
      .clk(clk), .rst(rst),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
      .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
      .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_wd(mem_wd), .mem_rd(mem_rd),
      .stall_cnt(stall_cnt)
   );

   dmem_port_arbiter #(.AW(32), .DW(32), .STARVE_MAX(1), .BURST_MAX(SAT_B)) dut_sat (
      .clk(clk), .rst(rst),
      .cpu_req(s_req), .cpu_we(1'b0), .cpu_addr(32'h0), .cpu_wdata(32'h0),
      .cpu_rdata(s_cpu_rdata), .cpu_stall(s_cpu_stall),
      .dma_req(s_req), .dma_we(1'b0), .dma_addr(32'h4), .dma_wdata(32'h0),
      .dma_gnt(s_dma_gnt), .dma_rvalid(s_dma_rvalid), .dma_rdata(s_dma_rdata),
      .mem_we(s_mem_we), .mem_addr(s_mem_addr), .mem_wd(s_mem_wd), .mem_rd(32'h0),
      .stall_cnt(s_stall_cnt)
   );

   assign mem_rd = ram[mem_addr[7:0]];

   initial begin
      for (int i = 0; i < 256; i++) ram[i] = 32'h0;
      forever begin
         @(posedge clk);
         if (mem_we) ram[mem_addr[7:0]] = mem_wd;
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic bit exp_sel();
      if (!rst || !dma_req) return 1'b0;
      if (m_run == 0) return !cpu_req || (m_wait >= STARVE);
      return !(cpu_req && (m_run >= BURST));
   endfunction

   task automatic model_reset();
      m_run = 0; m_wait = 0; m_stall = 0;
      m_rvalid = 1'b0; m_rdata = 32'h0;
      m_last_gnt = 1'b0; m_last_stall = 1'b0;
   endtask

   task automatic model_step();
      bit sel;
      sel = exp_sel();
      if (sel && !dma_we) m_rdata = ref_mem[dma_addr[7:0]];
      m_rvalid = sel && !dma_we;
      if (sel && dma_we) ref_mem[dma_addr[7:0]] = dma_wdata;
      else if (!sel && cpu_req && cpu_we) ref_mem[cpu_addr[7:0]] = cpu_wdata;
      if (cpu_req && sel && m_stall < 65535) m_stall++;
      if (sel) begin
         m_run++;
         m_wait = 0;
      end else begin
         m_run = 0;
         m_wait = dma_req ? m_wait + 1 : 0;
      end
      m_last_gnt = sel;
      m_last_stall = cpu_req && sel;
   endtask

   task automatic check_outputs();
      bit sel, we;
      sel = exp_sel();
      we  = sel ? dma_we : (rst && cpu_req && cpu_we);
      chk("dma_gnt", dma_gnt, sel);
      chk("cpu_stall", cpu_stall, cpu_req && sel);
      chk("mem_we", mem_we, we);
      chk("mem_addr", mem_addr, sel ? dma_addr : cpu_addr);
      if (we) chk("mem_wd", mem_wd, sel ? dma_wdata : cpu_wdata);
      if (rst && cpu_req && !sel && !cpu_we) chk("cpu_rdata", cpu_rdata, ref_mem[cpu_addr[7:0]]);
      chk("dma_rvalid", dma_rvalid, m_rvalid);
      chk("dma_rdata", dma_rdata, m_rdata);
      chk("stall_cnt", stall_cnt, m_stall);
   endtask

   task automatic cycle();
      @(negedge clk);
      check_outputs();
      @(posedge clk);
      if (rst) model_step();
      #1;
   endtask

   task automatic idle();
      cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 32'h0; cpu_wdata = 32'h0;
      dma_req = 1'b0; dma_we = 1'b0; dma_addr = 32'h0; dma_wdata = 32'h0;
   endtask

   task automatic reset_pulse();
      rst = 1'b0;
      model_reset();
      cycle();
      rst = 1'b1;
   endtask

   task automatic drive_random();
      if (!m_last_stall) begin
         cpu_req = ($urandom_range(0, 3) != 0);
         cpu_we = $urandom_range(0, 1);
         cpu_addr = $urandom_range(0, 31);
         cpu_wdata = $urandom;
      end
      if (!(dma_req && !m_last_gnt)) begin
         dma_req = ($urandom_range(0, 2) != 0);
         dma_we = $urandom_range(0, 1);
         dma_addr = $urandom_range(0, 31);
         dma_wdata = $urandom;
      end
   endtask

   function automatic int sat_expect(input int n);
      int s;
      s = n - (n + SAT_B) / (SAT_B + 1);
      return (s > 65535) ? 65535 : s;
   endfunction

   initial begin
      for (int i = 0; i < 256; i++) ref_mem[i] = 32'h0;
      s_req = 1'b0;
      idle();
      rst = 1'b0;
      model_reset();
      #2;
      chk("reset_stall_cnt", stall_cnt, 32'h0);
      chk("reset_rvalid", dma_rvalid, 32'h0);
      chk("reset_dma_gnt", dma_gnt, 32'h0);
      cycle();
      rst = 1'b1;

      // CPU-only store then load
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h10; cpu_wdata = 32'hDEADBEEF;
      #2 chk("cpu_store_stall", cpu_stall, 32'h0);
      cycle();
      cpu_we = 1'b0; cpu_wdata = 32'h0;
      #2 chk("cpu_load_stall", cpu_stall, 32'h0);
      chk("cpu_load_data", cpu_rdata, 32'hDEADBEEF);
      cycle();
      chk("cpu_only_stall_cnt", stall_cnt, 32'h0);

      // DMA-only write then read
      idle();
      dma_req = 1'b1; dma_we = 1'b1; dma_addr = 32'h20; dma_wdata = 32'h55;
      #2 chk("dma_write_gnt", dma_gnt, 32'h1);
      cycle();
      dma_we = 1'b0; dma_wdata = 32'h0;
      #2 chk("dma_read_gnt", dma_gnt, 32'h1);
      cycle();
      chk("dma_rvalid_pulse", dma_rvalid, 32'h1);
      chk("dma_rdata_val", dma_rdata, 32'h55);
      idle();
      cycle();
      chk("dma_rvalid_drop", dma_rvalid, 32'h0);

      // Continuous contention: 4 CPU cycles, 4 DMA cycles
      reset_pulse();
      for (int c = 0; c < 16; c++) begin
         cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = c;
         dma_req = 1'b1; dma_we = 1'b0; dma_addr = 32'h20;
         #2 chk("contend_stall", cpu_stall, ((c % 8) >= 4) ? 32'h1 : 32'h0);
         cycle();
      end
      chk("contend_stall_cnt", stall_cnt, 32'd8);

      // Long DMA run with idle CPU, then CPU arrives at a saturated burst
      reset_pulse();
      for (int c = 0; c < 10; c++) begin
         cpu_req = 1'b0; dma_req = 1'b1; dma_we = 1'b0; dma_addr = c;
         #2 chk("dma_run_gnt", dma_gnt, 32'h1);
         cycle();
      end
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h10;
      #2 chk("cpu_arrival_stall", cpu_stall, 32'h0);
      cycle();

      // Reset during beat 2 of a DMA write burst
      idle();
      reset_pulse();
      dma_req = 1'b1; dma_we = 1'b1; dma_addr = 32'h30; dma_wdata = 32'hA1;
      cycle();
      dma_addr = 32'h31; dma_wdata = 32'hA2;
      #2 rst = 1'b0;
      model_reset();
      cycle();
      dma_addr = 32'h32; dma_wdata = 32'hA3;
      #2 chk("rst_dma_gnt", dma_gnt, 32'h0);
      chk("rst_mem_we", mem_we, 32'h0);
      chk("rst_rvalid", dma_rvalid, 32'h0);
      chk("rst_stall_cnt", stall_cnt, 32'h0);
      cycle();
      idle();
      rst = 1'b1;
      cycle();
      chk("rst_beat1_written", ram[8'h30], 32'hA1);
      chk("rst_beat3_untouched", ram[8'h32], 32'h0);

      // Randomized traffic with occasional resets
      for (int n = 0; n < 3000; n++) begin
         if ($urandom_range(0, 199) == 0) begin
            reset_pulse();
         end else begin
            drive_random();
            cycle();
         end
      end

      // Stall counter saturation on a long-burst instance
      idle();
      reset_pulse();
      s_req = 1'b1;
      repeat (60060) @(posedge clk);
      #1 chk("sat_stall_cnt_pre", s_stall_cnt, sat_expect(60060));
      repeat (6006) @(posedge clk);
      #1 chk("sat_stall_cnt_hold", s_stall_cnt, sat_expect(66066));
      s_req = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
